// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, timing helper, command bytes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    WAITREL,
    DONE,
    ERR
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  // Microseconds to clock cycles; 64-bit product so long timeouts at MHz clocks do not overflow.
  function automatic int unsigned us_to_cycles(input int unsigned us, input int unsigned hz);
    logic [63:0] prod;
    prod = 64'(us) * 64'(hz);
    return 32'(prod / 64'd1000000);
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request channel between a command source and the PS/2 host transmitter.
// Latency: n/a (wiring only).
// Backpressure: tx_valid is only accepted while tx_ready is high; no queueing behind it.
// Signals: tx_data/tx_valid from the source; tx_ready, tx_done, tx_error, busy from the transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic       busy;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_error, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_error, busy
  );
endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchroniser for a raw PS/2 pin plus rise/fall detection on the synced level.
// Latency: level is 2 cycles behind the pin; edge flags are valid in the cycle the synced level changes.
// Backpressure: none (free running).
// Ports: i_clk, i_rst_n, i_pin (raw pin) -> o_level, o_fall, o_rise.
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Reset to the idle-high bus level so leaving reset never fakes a falling edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;
  assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10 bits on device clock falls, ACK check.
// Latency: tx_ready drops the cycle after the handshake; tx_done >= INHIBIT+2 cycles plus 11 device clocks.
// Backpressure: one byte in flight; tx_ready is high only in IDLE and requests while busy are dropped.
// Ports: i_clk, i_rst_n, tx_if (slave), i_ps2_clk/i_ps2_data raw pins, o_ps2_clk_oe/o_ps2_data_oe
//        (1 = pull line low). Board level ties each pin as pin = oe ? 1'b0 : 1'bz.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 3250000,
  parameter int unsigned INHIBIT_US   = 120,
  parameter int unsigned START_TMO_US = 15000,
  parameter int unsigned FRAME_TMO_US = 2000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  ps2_host_tx_if.slave tx_if,
  input  logic         i_ps2_clk,
  input  logic         i_ps2_data,
  output logic         o_ps2_clk_oe,
  output logic         o_ps2_data_oe
);

  localparam int unsigned INHIBIT_CYC = us_to_cycles(INHIBIT_US, CLK_HZ);
  localparam int unsigned START_CYC   = us_to_cycles(START_TMO_US, CLK_HZ);
  localparam int unsigned FRAME_CYC   = us_to_cycles(FRAME_TMO_US, CLK_HZ);
  localparam int unsigned MAX_AB      = (INHIBIT_CYC > START_CYC) ? INHIBIT_CYC : START_CYC;
  localparam int unsigned MAX_CYC     = (MAX_AB > FRAME_CYC) ? MAX_AB : FRAME_CYC;
  localparam int          TMR_W       = $clog2(MAX_CYC) + 1;

  // Timer counts down to zero inclusive, so N cycles of dwell need a load of N-1.
  localparam logic [TMR_W-1:0] INHIBIT_LOAD = TMR_W'(INHIBIT_CYC - 1);
  localparam logic [TMR_W-1:0] START_LOAD   = TMR_W'(START_CYC - 1);
  localparam logic [TMR_W-1:0] FRAME_LOAD   = TMR_W'(FRAME_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);

  logic w_clk_level, w_clk_fall, w_clk_rise;
  logic w_data_level, w_data_fall, w_data_rise;
  logic w_unused_edges;

  ps2_sync_edge u_sync_clk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_ps2_clk),
    .o_level (w_clk_level),
    .o_fall  (w_clk_fall),
    .o_rise  (w_clk_rise)
  );

  ps2_sync_edge u_sync_data (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_pin   (i_ps2_data),
    .o_level (w_data_level),
    .o_fall  (w_data_fall),
    .o_rise  (w_data_rise)
  );

  assign w_unused_edges = w_clk_rise ^ w_data_fall ^ w_data_rise;

  ps2_state_t       r_state, w_state_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [9:0]       r_shreg, w_shreg_nxt;
  logic [3:0]       r_bitcnt, w_bitcnt_nxt;
  logic             r_data_oe, w_data_oe_nxt;
  logic             w_clk_oe, w_data_oe, w_ready, w_busy, w_done, w_error;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_timer   <= '0;
      r_shreg   <= '0;
      r_bitcnt  <= '0;
      r_data_oe <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_shreg   <= w_shreg_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_data_oe <= w_data_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_shreg_nxt   = r_shreg;
    w_bitcnt_nxt  = r_bitcnt;
    w_data_oe_nxt = r_data_oe;
    w_clk_oe      = 1'b0;
    w_data_oe     = 1'b0;
    w_ready       = 1'b0;
    w_busy        = 1'b1;
    w_done        = 1'b0;
    w_error       = 1'b0;

    case (r_state)
      IDLE: begin
        w_busy  = 1'b0;
        w_ready = 1'b1;
        if (tx_if.tx_valid) begin
          w_shreg_nxt = {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
          w_timer_nxt = INHIBIT_LOAD;
          w_state_nxt = INHIBIT;
        end
      end
      INHIBIT: begin
        // Clock held low; any device clocking in progress is aborted and its edges are invisible.
        w_clk_oe = 1'b1;
        if (r_timer == '0) begin
          w_data_oe   = 1'b1;
          w_timer_nxt = START_LOAD;
          w_state_nxt = REQ;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
        end
      end
      REQ: begin
        // Start bit stays on the line through the first device clock, which the device samples.
        w_data_oe = 1'b1;
        if (w_clk_fall) begin
          w_bitcnt_nxt  = '0;
          w_data_oe_nxt = 1'b1;
          w_timer_nxt   = FRAME_LOAD;
          w_state_nxt   = BITS;
        end else if (r_timer == '0) begin
          w_state_nxt = ERR;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
        end
      end
      BITS: begin
        w_data_oe = r_data_oe;
        if (r_timer == '0) begin
          w_state_nxt = ERR;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
          if (w_clk_fall) begin
            w_data_oe_nxt = ~r_shreg[r_bitcnt];
            w_bitcnt_nxt  = r_bitcnt + 4'd1;
            if (r_bitcnt == 4'd9) w_state_nxt = ACK;
          end
        end
      end
      ACK: begin
        if (r_timer == '0) begin
          w_state_nxt = ERR;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
          if (w_clk_fall) w_state_nxt = w_data_level ? ERR : WAITREL;
        end
      end
      WAITREL: begin
        if (r_timer == '0) begin
          w_state_nxt = ERR;
        end else begin
          w_timer_nxt = r_timer - TMR_ONE;
          if (w_clk_level && w_data_level) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      ERR: begin
        w_error     = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_ps2_clk_oe   = w_clk_oe;
  assign o_ps2_data_oe  = w_data_oe;
  assign tx_if.tx_ready = w_ready;
  assign tx_if.busy     = w_busy;
  assign tx_if.tx_done  = w_done;
  assign tx_if.tx_error = w_error;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Latency: n/a.
// Backpressure: requests are issued only on tx_ready; extra requests while busy must be dropped.
module tb_ps2_host_tx;

  localparam int CLK_HALF = 154;    // one clock period stands for ~308 ns (3.25 MHz)
  localparam int BFM_HALF = 40000;  // 40 us device clock half period in the same units
  localparam longint HZ   = 3250000;
  localparam int INHIBIT_CYC = int'(HZ * 120 / 1000000);
  localparam int START_CYC   = int'(HZ * 15000 / 1000000);
  localparam int FRAME_CYC   = int'(HZ * 2000 / 1000000);
  localparam int ACK_NONE = 0, ACK_OK = 1, ACK_BAD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #(CLK_HALF) clk = ~clk;

  ps2_host_tx_if tx_if();
  logic clk_oe, data_oe;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  wire  ps2_clk  = !(clk_oe || dev_clk_low);
  wire  ps2_data = !(data_oe || dev_data_low);

  ps2_host_tx #(
    .CLK_HZ(3250000), .INHIBIT_US(120), .START_TMO_US(15000), .FRAME_TMO_US(2000)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .tx_if(tx_if),
    .i_ps2_clk(ps2_clk), .i_ps2_data(ps2_data),
    .o_ps2_clk_oe(clk_oe), .o_ps2_data_oe(data_oe)
  );

  int n_checks = 0, n_errors = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0, clk_hi_cnt = 0;
  int viol_idle = 0, viol_rdy = 0, viol_pulse = 0, hs_cnt = 0, n_sent = 0;
  int req_cyc = 0, err_cyc = 0, last_fall_cyc = 0;
  logic prev_clk_oe = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Expected line levels the device sees on its 11 rising edges: start, 8 data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_model(input logic [7:0] b);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    par = (ones % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!tx_if.busy && (clk_oe || data_oe)) viol_idle++;
    if (tx_if.tx_ready == tx_if.busy) viol_rdy++;
    if (clk_oe && data_oe) both_cnt++;
    if (clk_oe) clk_hi_cnt++;
    if (tx_if.tx_done) done_cnt++;
    if (tx_if.tx_error) begin err_cnt++; err_cyc = cyc; end
    if (tx_if.tx_done && tx_if.tx_error) viol_pulse++;
    if (prev_clk_oe && !clk_oe) req_cyc = cyc;
    prev_clk_oe = clk_oe;
  end

  always @(posedge clk) if (tx_if.tx_valid && tx_if.tx_ready) hs_cnt++;

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge clk);
    while (!tx_if.tx_ready && w < 5000) begin @(negedge clk); w++; end
    check("ready_before_send", tx_if.tx_ready, 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    n_sent++;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'($urandom);
    check("ready_drop", tx_if.tx_ready, 0);
    check("busy_rise", tx_if.busy, 1);
  endtask

  // Requests and data changes while the transmitter is busy; none may be taken.
  task automatic poke();
    repeat (3) begin
      repeat ($urandom_range(40, 250)) @(negedge clk);
      tx_if.tx_data  = 8'($urandom);
      tx_if.tx_valid = 1'b1;
      @(negedge clk);
      tx_if.tx_valid = 1'b0;
    end
  endtask

  task automatic dev(input int npulse, input int ack_mode, output logic [10:0] word, output int fcyc);
    int w;
    w = 0;
    word = '0;
    fcyc = 0;
    while (!(ps2_data == 1'b0 && ps2_clk == 1'b1) && w < 2000) begin @(negedge clk); w++; end
    check("dev_req_seen", (w < 2000), 1);
    #(BFM_HALF);
    for (int i = 0; i < npulse; i++) begin
      if (i == 0) fcyc = cyc;
      dev_clk_low = 1'b1;
      #(BFM_HALF);
      dev_clk_low = 1'b0;
      word[i] = ps2_data;
      #(BFM_HALF);
    end
    if (ack_mode != ACK_NONE) begin
      dev_data_low = (ack_mode == ACK_OK);
      #(BFM_HALF / 2);
      dev_clk_low = 1'b1;
      #(BFM_HALF);
      dev_clk_low  = 1'b0;
      dev_data_low = 1'b0;
      #(BFM_HALF);
    end
  endtask

  task automatic wait_end(input int d0, input int e0, input string tag);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 60000) begin @(negedge clk); w++; end
    check({tag, "_ended"}, (w < 60000), 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input int npulse, input int ack_mode,
                           input bit exp_done, input string tag);
    int d0, e0, b0, c0, fcyc;
    logic [10:0] got, exp, mask;
    d0 = done_cnt; e0 = err_cnt; b0 = both_cnt; c0 = clk_hi_cnt;
    exp = frame_model(b);
    send(b);
    fork
      dev(npulse, ack_mode, got, fcyc);
      poke();
    join
    last_fall_cyc = fcyc;
    wait_end(d0, e0, tag);
    mask = 11'((1 << npulse) - 1);
    if (npulse > 0) check({tag, "_bits"}, got & mask, exp & mask);
    check({tag, "_done"}, done_cnt - d0, exp_done ? 1 : 0);
    check({tag, "_error"}, err_cnt - e0, exp_done ? 0 : 1);
    check({tag, "_both_oe_cycles"}, both_cnt - b0, 1);
    check({tag, "_inhibit_cycles"}, clk_hi_cnt - c0, INHIBIT_CYC);
    check({tag, "_oe_released"}, {clk_oe, data_oe}, 0);
    check({tag, "_ready_after"}, tx_if.tx_ready, 1);
  endtask

  initial begin
    #(64'd200000 * 2 * CLK_HALF);
    $display("FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_clk_oe", clk_oe, 0);
    check("rst_data_oe", data_oe, 0);
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_if.busy, 0);
    check("rst_pulses", {tx_if.tx_done, tx_if.tx_error}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    run_frame(8'hED, 11, ACK_OK, 1'b1, "set_leds");
    run_frame(8'h07, 11, ACK_OK, 1'b1, "par0_07");
    run_frame(8'hFF, 11, ACK_OK, 1'b1, "par1_ff");

    // Device never clocks: start timeout counted from the end of inhibit.
    run_frame(8'($urandom), 0, ACK_NONE, 1'b0, "no_clock");
    check("no_clock_tmo_cycles", err_cyc - req_cyc, START_CYC);

    run_frame(8'($urandom), 11, ACK_BAD, 1'b0, "no_ack");

    // Device stops after 4 clocks: frame timeout measured from its first falling edge.
    run_frame(8'($urandom), 4, ACK_NONE, 1'b0, "stall");
    d = err_cyc - last_fall_cyc;
    check("stall_tmo_window", (d >= FRAME_CYC && d <= FRAME_CYC + 8), 1);
    if (d < FRAME_CYC || d > FRAME_CYC + 8)
      $display("  stall timeout took %0d cycles, allowed %0d..%0d", d, FRAME_CYC, FRAME_CYC + 8);

    // Reset in the middle of the data bits.
    begin
      logic [7:0]  b6;
      logic [10:0] g6, m6;
      int f6, d0, e0, np;
      b6 = 8'($urandom);
      np = $urandom_range(3, 7);
      d0 = done_cnt; e0 = err_cnt;
      send(b6);
      dev(np, ACK_NONE, g6, f6);
      m6 = 11'((1 << np) - 1);
      check("midreset_bits", g6 & m6, frame_model(b6) & m6);
      check("midreset_busy_before", tx_if.busy, 1);
      #(37);
      rst_n = 1'b0;
      #1;
      check("midreset_oe", {clk_oe, data_oe}, 0);
      check("midreset_ready", tx_if.tx_ready, 1);
      repeat (10) @(negedge clk);
      check("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
      rst_n = 1'b1;
      run_frame(8'h00, 11, ACK_OK, 1'b1, "after_reset_00");
    end

    check("handshakes", hs_cnt, n_sent);
    check("idle_oe_glitch", viol_idle, 0);
    check("ready_vs_busy", viol_rdy, 0);
    check("done_and_error", viol_pulse, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
